// File: rtl/crossover_pkg.sv
// crossover_pkg: mode codes, FSM states, gene field offsets and LFSR taps for crossover_pe
package crossover_pkg;
  localparam logic [1:0] MODE_SINGLE  = 2'd0;
  localparam logic [1:0] MODE_ALIGNED = 2'd1;
  localparam logic [1:0] MODE_UNIFORM = 2'd2;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  typedef enum logic {S_IDLE, S_RUN} state_e;
  function automatic int dst_lsb(input int weight_w);
    return weight_w;
  endfunction
  function automatic int src_lsb(input int node_w, input int weight_w);
    return node_w + weight_w;
  endfunction
  function automatic int innov_lsb(input int node_w, input int weight_w);
    return 2 * node_w + weight_w;
  endfunction
endpackage

// File: rtl/crossover_pe_lfsr16.sv
// lfsr16: 16-bit right-shifting Fibonacci LFSR (taps 16,14,13,11); ports clk, rst (sync active-low), en, q
module lfsr16 import crossover_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= SEED;
    else if (en) q <= {^(q & LFSR_TAPS), q[15:1]};
endmodule

// File: rtl/crossover_pe.sv
// crossover_pe: streaming NEAT crossover of two innovation-sorted parent streams (cfg, in_a, in_b, out handshakes; done pulse; out_count)
module crossover_pe import crossover_pkg::*; #(
  parameter int WEIGHT_W = 8,
  parameter int NODE_W = 8,
  parameter int INNOV_W = 8,
  parameter int FIT_W = 8,
  parameter int SIZE_W = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int GENE_W = INNOV_W + 2 * NODE_W + WEIGHT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [SIZE_W-1:0] cfg_xpt,
  input  logic [SIZE_W-1:0] cfg_size_a,
  input  logic [SIZE_W-1:0] cfg_size_b,
  input  logic [FIT_W-1:0]  cfg_fit_a,
  input  logic [FIT_W-1:0]  cfg_fit_b,
  input  logic              in_a_valid,
  output logic              in_a_ready,
  input  logic [GENE_W-1:0] in_a_gene,
  input  logic              in_b_valid,
  output logic              in_b_ready,
  input  logic [GENE_W-1:0] in_b_gene,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GENE_W-1:0] out_gene,
  output logic              done,
  output logic [SIZE_W:0]   out_count
);
  localparam int ILSB = innov_lsb(NODE_W, WEIGHT_W);
  state_e state_q;
  logic [1:0] mode_q;
  logic [SIZE_W-1:0] xpt_q, size_a_q, size_b_q, cnt_a_q, cnt_b_q, idx;
  logic [FIT_W-1:0] fit_a_q, fit_b_q;
  logic out_valid_q, done_q;
  logic [GENE_W-1:0] out_gene_q;
  logic [SIZE_W:0] out_count_q;
  logic [15:0] lfsr_q;
  logic [INNOV_W-1:0] inn_a, inn_b;
  logic run, ex_a, ex_b, slot_free, single, uniform, eq, a_fit, fire, take_a, take_b, sel_a, emit, finish;
  always_comb begin
    run = rst && state_q == S_RUN;
    ex_a = cnt_a_q == size_a_q;
    ex_b = cnt_b_q == size_b_q;
    slot_free = !out_valid_q || out_ready;
    single = mode_q == MODE_SINGLE;
    uniform = mode_q == MODE_UNIFORM;
    inn_a = in_a_gene[ILSB +: INNOV_W];
    inn_b = in_b_gene[ILSB +: INNOV_W];
    eq = !ex_a && !ex_b && inn_a == inn_b;
    a_fit = fit_a_q >= fit_b_q;
    idx = ex_a ? cnt_b_q : cnt_a_q;
    fire = run && !(ex_a && ex_b) && slot_free && (ex_a || in_a_valid) && (ex_b || in_b_valid);
    // single-point walks both parents in lockstep; other modes take the lower (or equal) head
    take_a = !ex_a && (single || ex_b || inn_a <= inn_b);
    take_b = !ex_b && (single || ex_a || inn_b <= inn_a);
    sel_a = single ? idx < xpt_q : eq ? (uniform ? !lfsr_q[0] : a_fit) : take_a;
    // unmatched genes survive only when they come from the fitter parent (ties favour A)
    emit = single ? (sel_a ? !ex_a : !ex_b) : eq || (take_a ? a_fit : !a_fit);
    finish = run && ex_a && ex_b && slot_free;
    in_a_ready = fire && take_a;
    in_b_ready = fire && take_b;
    cfg_ready = rst && state_q == S_IDLE;
  end
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en(fire && uniform && eq),
    .q(lfsr_q)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q <= '0;
      xpt_q <= '0;
      size_a_q <= '0;
      size_b_q <= '0;
      fit_a_q <= '0;
      fit_b_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      out_valid_q <= 1'b0;
      out_gene_q <= '0;
      out_count_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (out_ready) out_valid_q <= 1'b0;
      if (state_q == S_IDLE && cfg_valid) begin
        mode_q <= cfg_mode;
        xpt_q <= cfg_xpt;
        size_a_q <= cfg_size_a;
        size_b_q <= cfg_size_b;
        fit_a_q <= cfg_fit_a;
        fit_b_q <= cfg_fit_b;
        cnt_a_q <= '0;
        cnt_b_q <= '0;
        out_count_q <= '0;
        state_q <= S_RUN;
      end
      if (finish) state_q <= S_IDLE;
      if (fire) begin
        cnt_a_q <= cnt_a_q + SIZE_W'(take_a);
        cnt_b_q <= cnt_b_q + SIZE_W'(take_b);
        if (emit) begin
          out_valid_q <= 1'b1;
          out_gene_q <= sel_a ? in_a_gene : in_b_gene;
          out_count_q <= &out_count_q ? out_count_q : out_count_q + (SIZE_W + 1)'(1);
        end
      end
    end
  assign out_valid = out_valid_q;
  assign out_gene = out_gene_q;
  assign out_count = out_count_q;
  assign done = done_q;
endmodule

// File: tb/tb_crossover_pe.sv
// tb_crossover_pe: table-driven crossover jobs plus reset, backpressure and uniform-LFSR sequences
module tb_crossover_pe;
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] xpt, sa, sb, fa, fb;
    logic [7:0][7:0] ia, ib;
    logic [7:0] ne;
    logic [7:0][8:0] ep;
    logic [7:0] bp_at, bp_len, ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, in_a_valid, in_a_ready, in_b_valid, in_b_ready;
  logic out_valid, out_ready, done;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_xpt, cfg_size_a, cfg_size_b, cfg_fit_a, cfg_fit_b;
  logic [31:0] in_a_gene, in_b_gene, out_gene;
  logic [8:0] out_count;
  logic [15:0] lfsr_m;
  int ncmp = 0;
  int nbad = 0;
  vec_t tbl[8];
  vec_t u;
  always #5 clk = ~clk;
  crossover_pe dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_xpt(cfg_xpt),
    .cfg_size_a(cfg_size_a), .cfg_size_b(cfg_size_b), .cfg_fit_a(cfg_fit_a), .cfg_fit_b(cfg_fit_b),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_gene(in_a_gene),
    .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_gene(in_b_gene),
    .out_valid(out_valid), .out_ready(out_ready), .out_gene(out_gene),
    .done(done), .out_count(out_count)
  );
  function automatic logic [31:0] mk(input logic p, input logic [7:0] inn);
    return {inn, p ? 8'hB0 : 8'hA0, inn, inn ^ (p ? 8'h5A : 8'hC3)};
  endfunction
  function automatic logic [8:0] pa(input int i);
    return {1'b0, 8'(i)};
  endfunction
  function automatic logic [8:0] pb(input int i);
    return {1'b1, 8'(i)};
  endfunction
  function automatic logic [7:0][7:0] L(input logic [7:0] e0 = 0, e1 = 0, e2 = 0, e3 = 0, e4 = 0, e5 = 0, e6 = 0, e7 = 0);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction
  function automatic logic [7:0][8:0] E(input logic [8:0] e0 = 0, e1 = 0, e2 = 0, e3 = 0, e4 = 0, e5 = 0, e6 = 0, e7 = 0);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction
  function automatic vec_t mkv(input logic [1:0] m, input logic [7:0] xpt, sa, sb, fa, fb,
                               input logic [7:0][7:0] ia, ib, input logic [7:0] ne,
                               input logic [7:0][8:0] ep, input logic [7:0] bp_at, bp_len, ed);
    vec_t v;
    v.mode = m; v.xpt = xpt; v.sa = sa; v.sb = sb; v.fa = fa; v.fb = fb;
    v.ia = ia; v.ib = ib; v.ne = ne; v.ep = ep; v.bp_at = bp_at; v.bp_len = bp_len; v.ed = ed;
    return v;
  endfunction
  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask
  task automatic start_cfg(input vec_t v, input string tag);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode = v.mode; cfg_xpt = v.xpt; cfg_size_a = v.sa; cfg_size_b = v.sb;
    cfg_fit_a = v.fa; cfg_fit_b = v.fb;
    in_a_valid = 1'b0; in_b_valid = 1'b0; out_ready = 1'b1;
    #1 chk(tag, "cfg_ready idle", {31'd0, cfg_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic run_job(input vec_t v, input string tag);
    logic [31:0] ga[8], gb[8], got[$], held, e;
    int ai, bi, dstep, dcount;
    logic stalled, ahs, bhs;
    for (int i = 0; i < 8; i++) begin
      ga[i] = mk(1'b0, v.ia[i]);
      gb[i] = mk(1'b1, v.ib[i]);
    end
    ai = 0; bi = 0; dstep = -1; dcount = 0; stalled = 1'b0; held = '0;
    start_cfg(v, tag);
    for (int step = 0; step < 200; step++) begin
      in_a_valid = ai < int'(v.sa);
      in_a_gene = ai < 8 ? ga[ai] : '0;
      in_b_valid = bi < int'(v.sb);
      in_b_gene = bi < 8 ? gb[bi] : '0;
      out_ready = !(v.bp_len != 0 && step >= int'(v.bp_at) && step < int'(v.bp_at) + int'(v.bp_len));
      #1;
      if (done) begin
        dcount++;
        if (dstep < 0) dstep = step;
      end
      if (out_valid && out_ready) got.push_back(out_gene);
      if (out_valid && !out_ready) begin
        if (stalled) chk(tag, "held gene", out_gene, held);
        chk(tag, "stall readies", {30'd0, in_a_ready, in_b_ready}, 0);
        held = out_gene;
        stalled = 1'b1;
      end else stalled = 1'b0;
      ahs = in_a_valid && in_a_ready;
      bhs = in_b_valid && in_b_ready;
      @(posedge clk);
      ai += int'(ahs);
      bi += int'(bhs);
      @(negedge clk);
      if (dstep >= 0 && step >= dstep + 1) break;
    end
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
    chk(tag, "done seen", {31'd0, dstep >= 0}, 1);
    chk(tag, "done pulses", dcount, 1);
    chk(tag, "gene count", got.size(), {24'd0, v.ne});
    for (int i = 0; i < int'(v.ne); i++) begin
      e = mk(v.ep[i][8], v.ep[i][7:0]);
      chk(tag, $sformatf("gene %0d", i), i < got.size() ? got[i] : 32'hDEADBEEF, e);
    end
    chk(tag, "out_count", {23'd0, out_count}, {24'd0, v.ne});
    chk(tag, "consumed a", ai, {24'd0, v.sa});
    chk(tag, "consumed b", bi, {24'd0, v.sb});
    if (v.ed != 0) chk(tag, "done step", dstep, {24'd0, v.ed});
  endtask
  task automatic uniform_job(input string tag);
    u = mkv(2'd2, 0, 8, 8, 3, 3, L(1, 2, 3, 4, 5, 6, 7, 8), L(1, 2, 3, 4, 5, 6, 7, 8), 8, '0, 0, 0, 9);
    for (int i = 0; i < 8; i++) begin
      u.ep[i] = {lfsr_m[0], 8'(i + 1)};
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    run_job(u, tag);
  endtask
  initial begin
    tbl[0] = mkv(0, 2, 4, 4, 1, 1, L(1, 2, 3, 4), L(1, 2, 3, 4), 4, E(pa(1), pa(2), pb(3), pb(4)), 0, 0, 5);
    tbl[1] = mkv(1, 0, 3, 4, 9, 5, L(1, 2, 4), L(1, 3, 4, 6), 3, E(pa(1), pa(2), pa(4)), 0, 0, 0);
    tbl[2] = mkv(1, 0, 3, 4, 9, 12, L(1, 2, 4), L(1, 3, 4, 6), 4, E(pb(1), pb(3), pb(4), pb(6)), 0, 0, 0);
    tbl[3] = mkv(1, 0, 3, 4, 9, 5, L(1, 2, 4), L(1, 3, 4, 6), 3, E(pa(1), pa(2), pa(4)), 2, 5, 0);
    tbl[4] = mkv(1, 0, 0, 0, 1, 1, L(), L(), 0, E(), 0, 0, 1);
    tbl[5] = mkv(0, 4, 3, 5, 1, 1, L(1, 2, 3), L(1, 2, 3, 4, 5), 4, E(pa(1), pa(2), pa(3), pb(5)), 0, 0, 0);
    tbl[6] = mkv(3, 0, 2, 3, 7, 7, L(2, 5), L(1, 5, 9), 2, E(pa(2), pa(5)), 0, 0, 0);
    tbl[7] = mkv(0, 0, 2, 2, 1, 1, L(1, 2), L(1, 2), 2, E(pb(1), pb(2)), 0, 0, 0);
    rst = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_xpt = '0; cfg_size_a = '0; cfg_size_b = '0;
    cfg_fit_a = '0; cfg_fit_b = '0; in_a_valid = 1'b0; in_b_valid = 1'b0; in_a_gene = '0; in_b_gene = '0;
    out_ready = 1'b1; lfsr_m = 16'hACE1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", "cfg_ready in reset", {31'd0, cfg_ready}, 0);
    rst = 1'b1;
    #1;
    chk("reset", "cfg_ready", {31'd0, cfg_ready}, 1);
    chk("reset", "readies", {30'd0, in_a_ready, in_b_ready}, 0);
    chk("reset", "out_valid", {31'd0, out_valid}, 0);
    chk("reset", "done", {31'd0, done}, 0);
    chk("reset", "out_gene", out_gene, 0);
    chk("reset", "out_count", {23'd0, out_count}, 0);
    for (int k = 0; k < 8; k++) run_job(tbl[k], $sformatf("vec%0d", k));
    uniform_job("uniform1");
    uniform_job("uniform2");
    start_cfg(tbl[1], "midreset");
    in_a_valid = 1'b1; in_a_gene = mk(1'b0, 8'd1);
    in_b_valid = 1'b1; in_b_gene = mk(1'b1, 8'd1);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 chk("midreset", "out_valid before", {31'd0, out_valid}, 1);
    chk("midreset", "cfg_ready busy", {31'd0, cfg_ready}, 0);
    rst = 1'b0;
    #1 chk("midreset", "readies in reset", {30'd0, in_a_ready, in_b_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_a_valid = 1'b0; in_b_valid = 1'b0; out_ready = 1'b1;
    lfsr_m = 16'hACE1;
    #1;
    chk("midreset", "out_valid", {31'd0, out_valid}, 0);
    chk("midreset", "cfg_ready", {31'd0, cfg_ready}, 1);
    chk("midreset", "out_count", {23'd0, out_count}, 0);
    run_job(tbl[0], "after reset");
    uniform_job("uniform reseeded");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/crossover_pe.md
# crossover_pe

Parametrised streaming crossover engine for the NEAT mating array, successor to the single-gene mating PE. Consumes two parent genome streams sorted by innovation number, each with its own valid/ready handshake. Emits the child genome as a valid/ready stream. Supports three modes:
- single-point crossover;
- innovation-aligned NEAT crossover, where disjoint and excess genes come from the fitter parent;
- uniform LFSR-driven crossover.

## Interface
- WEIGHT_W, 8, link-weight field width
- NODE_W, 8, source/destination node-number width
- INNOV_W, 8, innovation-number width
- FIT_W, 8, parent-fitness width
- SIZE_W, 8, gene-count width (max genome length 2^SIZE_W-1)
- LFSR_SEED, 16'hACE1, uniform-mode LFSR reset value (must be nonzero)
- GENE_W (derived) = INNOV_W+2*NODE_W+WEIGHT_W; gene layout {innov, src, dst, weight}, MSB first
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cfg_valid / cfg_ready  in / out  1  job-configuration handshake
- cfg_mode  in  2  0 single-point, 1 aligned, 2 uniform, 3 reserved (treated as aligned)
- cfg_xpt  in  SIZE_W  single-point crossover index
- cfg_size_a, cfg_size_b  in  SIZE_W  parent gene counts
- cfg_fit_a, cfg_fit_b  in  FIT_W  parent fitness
- in_a_valid / in_a_ready  in / out  1  parent-A gene handshake; in_a_gene  in  GENE_W
- in_b_valid / in_b_ready  in / out  1  parent-B gene handshake; in_b_gene  in  GENE_W
- out_valid / out_ready  out / in  1  child gene handshake; out_gene  out  GENE_W
- done  out  1  one-cycle pulse, job complete
- out_count  out  SIZE_W+1  genes emitted in current/last job

## Operation
- Config fields are latched on a cfg handshake. cnt_a and cnt_b (genes consumed per parent) are cleared, out_count is cleared, and the FSM enters RUN.
- Exhaustion: parent A is exhausted when cnt_a==size_a; same rule for B.
- A step fires when all required inputs are valid and the output slot is free (out_valid==0 or out_ready==1). Each fired step consumes inputs and loads at most one child gene.
- Single-point: step index i is the current parent index (cnt_a, or cnt_b if A is exhausted).
  - Consumes every non-exhausted parent in lockstep.
  - Emits A's gene if i<xpt, otherwise B's gene.
  - No emission if the selected parent is exhausted.
- Aligned and uniform modes compare head innovation numbers.
  - Equal innovation: consume both. Emit A if fit_a>=fit_b (aligned mode) or if lfsr[0]==0 (uniform mode); otherwise emit B.
  - A<B, or B exhausted: consume A; emit it only if fit_a>=fit_b.
  - B<A, or A exhausted: consume B; emit it only if fit_b>fit_a.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances only on uniform-mode equal-innovation steps. Loaded with LFSR_SEED on reset only, never per job.
- Completion: in RUN with both parents exhausted and the output slot free, the FSM goes to IDLE and done pulses.
- Zero-size parents complete with no output.
- cfg_valid is ignored outside IDLE.

## Timing
- FSM states: IDLE (cfg_ready=1) → RUN on cfg handshake; RUN → IDLE on completion.
- in_x_ready is combinational from state, exhaustion, head comparison and the free-output-slot condition. It is never asserted in IDLE.
- Latency: a gene consumed at edge t appears on out_gene in the cycle after t (registered output).
- Sustained throughput is 1 step/cycle with out_ready held high.
- Backpressure: out_gene and out_valid stay stable until out_ready. Input readies stay low while the output slot is blocked.
- done is registered: a cfg handshake at edge t gives done high for exactly one cycle, no earlier than cycle t+2.
- Reset values: cfg_ready=0 during reset and 1 after; in_a_ready=in_b_ready=out_valid=done=0; out_gene=0; out_count=0; FSM=IDLE.
- Reset mid-job discards all state and any held output gene.
- Simultaneous completion and output acceptance in the same cycle completes normally.
- out_count saturates at 2^(SIZE_W+1)-1 (unreachable for legal sizes).

## Structure
- Package crossover_pkg holds:
  - mode constants MODE_SINGLE, MODE_ALIGNED and MODE_UNIFORM;
  - FSM state enum;
  - gene field-offset functions/localparams;
  - LFSR tap constant.
- Sub-module lfsr16 has ports clk, rst, en, and q[15:0], with the seed as a parameter. All other logic stays flat.

## Test plan
- Single-point: size_a=size_b=4, xpt=2, A innovs 1–4, B innovs 1–4 → out A1,A2,B3,B4; out_count=4; done pulses once.
- Aligned, A fitter: fit_a=9, fit_b=5, A {1,2,4}, B {1,3,4,6} → out A1,A2,A4; B3 and B6 dropped.
- Aligned, B fitter: same parents with fit_b=12 → out B1,B3,B4,B6.
- Backpressure: hold out_ready low 5 cycles mid-job → out_gene stable, both in_x_ready low, no gene lost or duplicated.
- Empty job: size_a=size_b=0 → no out_valid; done exactly once, 2 cycles after the cfg handshake.
- Uniform, seed 0xACE1, 8 matching genes → selections match a reference LFSR model.
- Reset: assert rst low for one cycle mid-RUN with out_valid high → next cycle out_valid=0, cfg_ready=1, out_count=0.
